// File: rtl/id_decode_queue.sv
// RV32I (+optional RV32E restriction and RV32M) decoder feeding a small FIFO of
// decoded records; the head record drives the outputs, all zero when empty.
module id_decode_queue #(
  parameter int DEPTH    = 2,
  parameter bit RV32E    = 1'b0,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [31:0]                i_in_pc,
  input  logic [31:0]                i_in_inst,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [31:0]                o_out_pc,
  output logic [31:0]                o_out_inst,
  output logic [31:0]                o_out_imm,
  output logic [4:0]                 o_out_rd,
  output logic [4:0]                 o_out_rs1,
  output logic [4:0]                 o_out_rs2,
  output logic [4:0]                 o_out_alu_op,
  output logic [2:0]                 o_out_mem_len,
  output logic                       o_out_reg_write,
  output logic                       o_out_mem_read,
  output logic                       o_out_mem_write,
  output logic                       o_out_jal,
  output logic                       o_out_jalr,
  output logic                       o_out_branch,
  output logic                       o_out_csr,
  output logic                       o_out_ecall,
  output logic                       o_out_mret,
  output logic                       o_out_illegal,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  alu_op;
    logic [2:0]  mem_len;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        jal;
    logic        jalr;
    logic        branch;
    logic        csr;
    logic        ecall;
    logic        mret;
    logic        illegal;
  } rec_t;

  function automatic logic [4:0] f_arith(input logic [2:0] f3);
    case (f3)
      3'd0:    f_arith = 5'd0;
      3'd1:    f_arith = 5'd7;
      3'd2:    f_arith = 5'd5;
      3'd3:    f_arith = 5'd6;
      3'd4:    f_arith = 5'd4;
      3'd5:    f_arith = 5'd8;
      3'd6:    f_arith = 5'd3;
      default: f_arith = 5'd2;
    endcase
  endfunction

  function automatic logic [2:0] f_len(input logic [2:0] f3);
    case (f3)
      3'd0:    f_len = 3'd2;
      3'd1:    f_len = 3'd1;
      3'd4:    f_len = 3'd4;
      3'd5:    f_len = 3'd3;
      default: f_len = 3'd0;
    endcase
  endfunction

  rec_t           w_dec;
  rec_t           w_head;
  logic [2:0]     w_f3;
  logic [6:0]     w_f7;
  logic           w_ill;
  logic           w_use_rd;
  logic           w_use_rs1;
  logic           w_use_rs2;
  logic           w_push;
  logic           w_pop;

  rec_t           r_mem [DEPTH];
  logic [AW-1:0]  r_wp;
  logic [AW-1:0]  r_rp;
  logic [CW-1:0]  r_count;

  assign w_f3 = i_in_inst[14:12];
  assign w_f7 = i_in_inst[31:25];

  always_comb begin
    w_dec      = '0;
    w_ill      = 1'b0;
    w_use_rd   = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_dec.pc   = i_in_pc;
    w_dec.inst = i_in_inst;
    w_dec.rd   = i_in_inst[11:7];
    w_dec.rs1  = i_in_inst[19:15];
    w_dec.rs2  = i_in_inst[24:20];
    case (i_in_inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        w_dec.imm       = {i_in_inst[31:12], 12'b0};
        w_dec.reg_write = 1'b1;
        w_use_rd        = 1'b1;
      end
      OPC_JAL: begin
        w_dec.imm       = {{12{i_in_inst[31]}}, i_in_inst[19:12], i_in_inst[20],
                           i_in_inst[30:21], 1'b0};
        w_dec.jal       = 1'b1;
        w_dec.reg_write = 1'b1;
        w_use_rd        = 1'b1;
      end
      OPC_JALR: begin
        w_dec.imm       = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
        w_dec.jalr      = 1'b1;
        w_dec.reg_write = 1'b1;
        w_use_rd        = 1'b1;
        w_use_rs1       = 1'b1;
        w_ill           = (w_f3 != 3'd0);
      end
      OPC_BRANCH: begin
        w_dec.imm    = {{20{i_in_inst[31]}}, i_in_inst[7], i_in_inst[30:25],
                        i_in_inst[11:8], 1'b0};
        w_dec.branch = 1'b1;
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        case (w_f3)
          3'd0, 3'd1: w_dec.alu_op = ALU_SUB;
          3'd4, 3'd5: w_dec.alu_op = ALU_SLT;
          3'd6, 3'd7: w_dec.alu_op = ALU_SLTU;
          default:    w_ill        = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_dec.imm       = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
        w_dec.mem_read  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.mem_len   = f_len(w_f3);
        w_use_rd        = 1'b1;
        w_use_rs1       = 1'b1;
        w_ill           = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      OPC_STORE: begin
        w_dec.imm       = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
        w_dec.mem_write = 1'b1;
        w_dec.mem_len   = (w_f3 <= 3'd2) ? f_len(w_f3) : 3'd0;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_ill           = (w_f3 > 3'd2);
      end
      OPC_OPIMM: begin
        w_dec.imm       = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = (w_f3 == 3'd5 && i_in_inst[30]) ? ALU_SRA : f_arith(w_f3);
        w_use_rd        = 1'b1;
        w_use_rs1       = 1'b1;
      end
      OPC_OP: begin
        w_dec.reg_write = 1'b1;
        w_use_rd        = 1'b1;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        if (w_f7 == 7'b0000000) begin
          w_dec.alu_op = f_arith(w_f3);
        end else if (w_f7 == 7'b0100000) begin
          w_dec.alu_op = (w_f3 == 3'd0) ? ALU_SUB :
                         (w_f3 == 3'd5) ? ALU_SRA : f_arith(w_f3);
        end else if (ENABLE_M && w_f7 == 7'b0000001) begin
          w_dec.alu_op = ALU_MUL + {2'b00, w_f3};
        end else begin
          w_dec.alu_op = f_arith(w_f3);
          w_ill        = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (w_f3 == 3'd0) begin
          if (i_in_inst == 32'h0000_0073)      w_dec.ecall = 1'b1;
          else if (i_in_inst == 32'h3020_0073) w_dec.mret  = 1'b1;
          else                                 w_ill       = 1'b1;
        end else if (w_f3 == 3'd4) begin
          w_ill = 1'b1;
        end else begin
          w_dec.csr       = 1'b1;
          w_dec.reg_write = 1'b1;
          w_use_rd        = 1'b1;
          // immediate CSR forms carry a 5-bit zimm in the rs1 field
          if (w_f3[2]) w_dec.imm = {27'b0, i_in_inst[19:15]};
          else         w_use_rs1 = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
    if (RV32E && ((w_use_rd && i_in_inst[11]) || (w_use_rs1 && i_in_inst[19]) ||
                  (w_use_rs2 && i_in_inst[24])))
      w_ill = 1'b1;
    if (w_ill) begin
      w_dec.reg_write = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.jal       = 1'b0;
      w_dec.jalr      = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.csr       = 1'b0;
      w_dec.ecall     = 1'b0;
      w_dec.mret      = 1'b0;
    end
    w_dec.illegal = w_ill;
  end

  assign o_in_ready  = (r_count != CW'(DEPTH)) && !i_flush;
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;

  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wp] <= w_dec;
  end

  // flush shares the reset path; pop is dropped and push is already blocked by in_ready
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = o_out_valid ? r_mem[r_rp] : '0;

  assign o_out_pc        = w_head.pc;
  assign o_out_inst      = w_head.inst;
  assign o_out_imm       = w_head.imm;
  assign o_out_rd        = w_head.rd;
  assign o_out_rs1       = w_head.rs1;
  assign o_out_rs2       = w_head.rs2;
  assign o_out_alu_op    = w_head.alu_op;
  assign o_out_mem_len   = w_head.mem_len;
  assign o_out_reg_write = w_head.reg_write;
  assign o_out_mem_read  = w_head.mem_read;
  assign o_out_mem_write = w_head.mem_write;
  assign o_out_jal       = w_head.jal;
  assign o_out_jalr      = w_head.jalr;
  assign o_out_branch    = w_head.branch;
  assign o_out_csr       = w_head.csr;
  assign o_out_ecall     = w_head.ecall;
  assign o_out_mret      = w_head.mret;
  assign o_out_illegal   = w_head.illegal;
  assign o_count         = r_count;

endmodule

// File: doc/id_decode_queue.md
ID_DECODE_QUEUE -- requirements
Module: id_decode_queue

Interface
REQ-001 Parameter DEPTH, 2, decoded-entry queue depth; power of two, >=2.
REQ-002 Parameter RV32E, 0, 1 = only x0-x15 legal.
REQ-003 Parameter ENABLE_M, 0, 1 = decode RV32M on OP opcode.
REQ-004 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 flush  in  1  discard all queued and incoming entries.
REQ-007 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-008 in_pc, in_inst  in  32, 32  fetched PC and instruction.
REQ-009 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-010 out_pc, out_inst, out_imm  out  32 each  head entry PC, raw instruction, sign-extended immediate.
REQ-011 out_rd, out_rs1, out_rs2  out  5 each  register indices.
REQ-012 out_alu_op  out  5  ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9 MUL10 MULH11 MULHSU12 MULHU13 DIV14 DIVU15 REM16 REMU17.
REQ-013 out_mem_len  out  3  W0 H1 B2 HU3 BU4.
REQ-014 out_reg_write, out_mem_read, out_mem_write, out_jal, out_jalr, out_branch, out_csr, out_ecall, out_mret, out_illegal  out  1 each  decoded controls.
REQ-015 count  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-016 Decode SHALL be combinational on in_inst; decoded record SHALL be written to queue tail on in_valid && in_ready.
REQ-017 in_ready SHALL be (count != DEPTH) && !flush; no push when full, even if popping same cycle.
REQ-018 out_valid SHALL be (count != 0); all out_* payloads SHALL be 0 when count == 0.
REQ-019 Pop SHALL occur on out_valid && out_ready; head advances next cycle.
REQ-020 Latency: entry accepted in cycle N SHALL appear on outputs in cycle N+1 when queue was empty.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH.
REQ-023 flush SHALL set count, pointers to 0 next cycle; pop/push in flush cycle ignored.
REQ-024 Immediates: I (load, OP-IMM, JALR), S, B, U (LUI, AUIPC), J per RV32I; CSR-immediate forms SHALL give zero-extended inst[19:15]; R-type, ECALL, MRET 0.
REQ-025 reg_write SHALL be 1 for LUI, AUIPC, JAL, JALR, load, OP-IMM, OP, CSR Zicsr ops; mem_read for load; mem_write for store.
REQ-026 Branch SHALL set out_branch and alu_op SUB (BEQ/BNE), SLT (BLT/BGE), SLTU (BLTU/BGEU).
REQ-027 OP with funct7 0100000 SHALL select SUB/SRA; OP-IMM funct3 101 with inst[30] SHALL select SRA.
REQ-028 SYSTEM: inst 0x00000073 SHALL set out_ecall; 0x30200073 out_mret; funct3 != 0 sets out_csr.
REQ-029 out_illegal SHALL be 1 for: inst[1:0] != 11; unknown opcode; JALR funct3 != 0; load funct3 in {3,6,7}; store funct3 > 2; branch funct3 in {2,3}; OP funct7 not in {0000000,0100000} unless ENABLE_M and 0000001; SYSTEM funct3 0 not ECALL/MRET; funct3 = 4 on SYSTEM.
REQ-030 RV32E=1: any used rd/rs1/rs2 >= 16 SHALL set out_illegal.
REQ-031 Illegal entries SHALL be queued with reg_write, mem_read, mem_write, jal, jalr, branch, csr, ecall, mret forced to 0.

Reset
REQ-032 reset SHALL take priority over flush and handshakes; next cycle count = 0, pointers = 0, out_valid = 0, in_ready = 1, all payloads 0.
REQ-033 reset mid-stream SHALL discard all queued entries; no entry popped in reset cycle is valid.

Verification
REQ-034 Push 0x00500093 at PC 0x80000000, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op=0, reg_write=1.
REQ-035 DEPTH=2, out_ready=0, push 0x0080A103 then 0x00112223 -> count=2, in_ready=0; first pop shows mem_read=1, mem_len=0, imm=8; second mem_write=1, imm=4.
REQ-036 Full queue, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; flush-cycle input not visible.
REQ-037 ENABLE_M=0 push 0x022081B3 -> out_illegal=1, reg_write=0; ENABLE_M=1 -> alu_op=10, reg_write=1, illegal=0.
REQ-038 RV32E=1 push 0x00000813 -> out_illegal=1; RV32E=0 -> legal, rd=16.
REQ-039 Continuous push/pop at 1 per cycle for 3*DEPTH instructions -> outputs in order, count constant at 1, no drops.
